// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the dual-clock FIFO controllers: Gray/binary
// conversion and the pointer-width rule (one extra wrap bit over the RAM address).
package fifo_ptr_pkg;

    localparam int CONV_W = 32;

    // Pointers are one bit wider than the RAM address so full and empty differ.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Works for any width up to CONV_W when the argument is zero-extended.
    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
        logic [CONV_W-1:0] bin;
        bin = {CONV_W{1'b0}};
        bin[CONV_W-1] = gray[CONV_W-1];
        for (int i = CONV_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all
// Gray bits at or above it. Shared by the read- and write-side controllers.
module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/read_ptr_ctrl.sv
// Read-side pointer controller for the CDC FIFO: binary/Gray read pointers,
// empty/almost-empty, read-valid strobe and sticky underflow. READ_LEVEL_EN adds read_level.
module read_ptr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int ADDR_WIDTH    = 3,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  read_clk,
    input  logic                  read_rst,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH:0]   write_pointer_sync,
    output logic [ADDR_WIDTH:0]   read_pointer,
    output logic [ADDR_WIDTH:0]   read_gray_pointer,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  read_valid,
`ifdef READ_LEVEL_EN
    output logic [ADDR_WIDTH:0]   read_level,
`endif
    output logic                  underflow
);

    localparam int               PTR_W       = ptr_width(ADDR_WIDTH);
    localparam logic [PTR_W-1:0] AE_THRESH_C = PTR_W'(AEMPTY_THRESH);

    logic             accept_s;
    logic [PTR_W-1:0] ptr_next_s;
    logic [PTR_W-1:0] gray_next_s;
    logic [PTR_W-1:0] wbin_s;
    logic [PTR_W-1:0] level_next_s;
    logic             empty_next_s;
    logic             aempty_next_s;
    logic             underflow_next_s;

    logic [PTR_W-1:0] read_pointer_r;
    logic [PTR_W-1:0] read_gray_pointer_r;
    logic             empty_r;
    logic             almost_empty_r;
    logic             read_valid_r;
    logic             underflow_r;

    gray_to_bin #(.WIDTH(PTR_W)) u_wptr_g2b (
        .gray (write_pointer_sync),
        .bin  (wbin_s)
    );

    // Next-state: a read accept and a write-pointer advance fold into one update.
    always_comb begin
        accept_s         = read_enable & ~empty_r;
        ptr_next_s       = read_pointer_r + {{(PTR_W-1){1'b0}}, accept_s};
        gray_next_s      = PTR_W'(bin2gray(CONV_W'(ptr_next_s)));
        empty_next_s     = (gray_next_s == write_pointer_sync);
        level_next_s     = wbin_s - ptr_next_s;
        aempty_next_s    = (level_next_s <= AE_THRESH_C);
        underflow_next_s = underflow_r | (read_enable & empty_r);
    end

    // State registers; synchronous reset wins over every other input.
    always_ff @(posedge read_clk) begin
        if (read_rst) begin
            read_pointer_r      <= {PTR_W{1'b0}};
            read_gray_pointer_r <= {PTR_W{1'b0}};
            empty_r             <= 1'b1;
            almost_empty_r      <= 1'b1;
            read_valid_r        <= 1'b0;
            underflow_r         <= 1'b0;
        end else begin
            read_pointer_r      <= ptr_next_s;
            read_gray_pointer_r <= gray_next_s;
            empty_r             <= empty_next_s;
            almost_empty_r      <= aempty_next_s;
            read_valid_r        <= accept_s;
            underflow_r         <= underflow_next_s;
        end
    end

`ifdef READ_LEVEL_EN
    logic [PTR_W-1:0] read_level_r;

    // Occupancy register, only present when the level port is built.
    always_ff @(posedge read_clk) begin
        if (read_rst) begin
            read_level_r <= {PTR_W{1'b0}};
        end else begin
            read_level_r <= level_next_s;
        end
    end

    assign read_level = read_level_r;
`endif

    assign read_pointer      = read_pointer_r;
    assign read_gray_pointer = read_gray_pointer_r;
    assign read_addr         = read_pointer_r[ADDR_WIDTH-1:0];
    assign empty             = empty_r;
    assign almost_empty      = almost_empty_r;
    assign read_valid        = read_valid_r;
    assign underflow         = underflow_r;

endmodule

// File: tb/tb_read_ptr_ctrl.sv
// Self-checking bench for read_ptr_ctrl (ADDR_WIDTH=3, AEMPTY_THRESH=2):
// table of per-cycle vectors plus hand-built sequences, checked through a scoreboard queue.
module tb_read_ptr_ctrl;

    logic       read_clk = 1'b0;
    logic       read_rst = 1'b1;
    logic       read_enable = 1'b0;
    logic [3:0] write_pointer_sync = 4'b0000;
    logic [3:0] read_pointer;
    logic [3:0] read_gray_pointer;
    logic [2:0] read_addr;
    logic       empty;
    logic       almost_empty;
    logic       read_valid;
    logic       underflow;
`ifdef READ_LEVEL_EN
    logic [3:0] read_level;
`endif

    typedef struct {
        logic       rst;
        logic       re;
        logic [3:0] wps;
        logic [3:0] ptr;
        logic [3:0] gray;
        logic       e;
        logic       ae;
        logic       v;
        logic       u;
        logic [3:0] lvl;
        string      tag;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    read_ptr_ctrl #(.ADDR_WIDTH(3), .AEMPTY_THRESH(2)) dut (
        .read_clk           (read_clk),
        .read_rst           (read_rst),
        .read_enable        (read_enable),
        .write_pointer_sync (write_pointer_sync),
        .read_pointer       (read_pointer),
        .read_gray_pointer  (read_gray_pointer),
        .read_addr          (read_addr),
        .empty              (empty),
        .almost_empty       (almost_empty),
        .read_valid         (read_valid),
`ifdef READ_LEVEL_EN
        .read_level         (read_level),
`endif
        .underflow          (underflow)
    );

    always #5 read_clk = ~read_clk;

    function automatic logic [3:0] tb_gray(input logic [3:0] b);
        return b ^ {1'b0, b[3:1]};
    endfunction

    function automatic vec_t mk(input string tag, input logic rst, input logic re,
                                input logic [3:0] wps, input logic [3:0] ptr,
                                input logic [3:0] gray, input logic e, input logic ae,
                                input logic v, input logic u, input logic [3:0] lvl);
        vec_t t;
        t.tag = tag; t.rst = rst; t.re = re; t.wps = wps; t.ptr = ptr; t.gray = gray;
        t.e = e; t.ae = ae; t.v = v; t.u = u; t.lvl = lvl;
        return t;
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    // Drive one cycle, record its expectation, then compare after the edge.
    task automatic apply(input vec_t v);
        vec_t x;
        @(negedge read_clk);
        read_rst           = v.rst;
        read_enable        = v.re;
        write_pointer_sync = v.wps;
        exp_q.push_back(v);
        @(posedge read_clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            x = exp_q.pop_front();
            chk({x.tag, ".ptr"},   int'(read_pointer),      int'(x.ptr));
            chk({x.tag, ".gray"},  int'(read_gray_pointer), int'(x.gray));
            chk({x.tag, ".addr"},  int'(read_addr),         int'(x.ptr[2:0]));
            chk({x.tag, ".empty"}, int'(empty),             int'(x.e));
            chk({x.tag, ".aempty"},int'(almost_empty),      int'(x.ae));
            chk({x.tag, ".valid"}, int'(read_valid),        int'(x.v));
            chk({x.tag, ".uflow"}, int'(underflow),         int'(x.u));
`ifdef READ_LEVEL_EN
            chk({x.tag, ".level"}, int'(read_level),        int'(x.lvl));
`endif
        end
    endtask

    initial begin
        logic [3:0] p;
        logic [3:0] lv;

        // Reset, underflow, fill/drain.
        vecs.push_back(mk("rst0",   1'b1, 1'b0, 4'b0000, 4'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
        vecs.push_back(mk("rst1",   1'b1, 1'b0, 4'b0000, 4'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
        vecs.push_back(mk("uflow",  1'b0, 1'b1, 4'b0000, 4'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0));
        foreach (vecs[i]) apply(vecs[i]);
        vecs.delete();

        // Underflow must stay set with no further reads.
        for (int i = 0; i < 10; i++)
            apply(mk("uflow_hold", 1'b0, 1'b0, 4'b0000, 4'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0));

        vecs.push_back(mk("fill5",  1'b0, 1'b0, 4'b0111, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5));
        vecs.push_back(mk("rd1",    1'b0, 1'b1, 4'b0111, 4'd1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4));
        vecs.push_back(mk("rd2",    1'b0, 1'b1, 4'b0111, 4'd2, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3));
        vecs.push_back(mk("rd3",    1'b0, 1'b1, 4'b0111, 4'd3, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2));
        vecs.push_back(mk("rd4",    1'b0, 1'b1, 4'b0111, 4'd4, 4'b0110, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1));
        vecs.push_back(mk("rd5",    1'b0, 1'b1, 4'b0111, 4'd5, 4'b0111, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0));
        vecs.push_back(mk("idle",   1'b0, 1'b0, 4'b0111, 4'd5, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk("wp15",   1'b0, 1'b0, 4'b1000, 4'd5, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10));
        foreach (vecs[i]) apply(vecs[i]);
        vecs.delete();

        // Walk the read pointer up to 15 against a write pointer of 15.
        for (int k = 1; k <= 10; k++) begin
            p  = 4'(5 + k);
            lv = 4'(10 - k);
            apply(mk("walk", 1'b0, 1'b1, 4'b1000, p, tb_gray(p),
                     (lv == 4'd0), (lv <= 4'd2), 1'b1, 1'b1, lv));
        end

        // Wrap from 15 to 0, then drain to empty.
        apply(mk("wp1",     1'b0, 1'b0, 4'b0001, 4'd15, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2));
        apply(mk("wrap",    1'b0, 1'b1, 4'b0001, 4'd0,  4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1));
        apply(mk("wrap_e",  1'b0, 1'b1, 4'b0001, 4'd1,  4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0));

        // Bring the read pointer to 6 with write pointer 7 (occupancy 1).
        apply(mk("wp7",     1'b0, 1'b0, 4'b0100, 4'd1,  4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6));
        for (int k = 2; k <= 6; k++) begin
            p  = 4'(k);
            lv = 4'(7 - k);
            apply(mk("to6", 1'b0, 1'b1, 4'b0100, p, tb_gray(p), 1'b0, (lv <= 4'd2), 1'b1, 1'b1, lv));
        end

        // Read and write in the same cycle: net occupancy unchanged, stays non-empty.
        apply(mk("simul",   1'b0, 1'b1, 4'b1100, 4'd7,  4'b0100, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1));

        // Mid-operation reset with a read request pending.
        apply(mk("lvl4",    1'b0, 1'b0, 4'b1110, 4'd7,  4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4));
        apply(mk("midrst",  1'b1, 1'b1, 4'b1110, 4'd0,  4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
        apply(mk("postrst", 1'b0, 1'b0, 4'b0000, 4'd0,  4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0));

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
